// File: rtl/graphics_pkg.sv
// Shared definitions for the graphics_anim pixel generator.
//   PIX_W          : width of pix_x / pix_y / robot_x
//   COL_*          : 3-bit RGB colour constants
//   robot_state_t  : movement state of the robot sprite
package graphics_pkg;
  localparam int PIX_W = 10;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_BG    = 3'b110;
  localparam logic [2:0] COL_WALL  = 3'b001;
  localparam logic [2:0] COL_ROBOT = 3'b100;

  typedef enum logic [1:0] {IDLE, RIGHT, LEFT} robot_state_t;
endpackage

// File: rtl/graphics_anim_robot_mover.sv
// robot_mover: horizontal position FSM for the robot sprite.
// The robot sweeps between L and XMAX, bouncing at each end, and advances
// only on cycles where frame_tick and run are both high.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   frame_tick  : one-clk pulse per frame
//   run         : enables motion
//   robot_x     : left edge of the sprite
import graphics_pkg::*;

module robot_mover #(
  parameter int L       = 41,
  parameter int XMAX    = 494,
  parameter int ROBOT_V = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             run,
  output logic [PIX_W-1:0] robot_x
);
  localparam logic [PIX_W-1:0] L_X    = PIX_W'(L);
  localparam logic [PIX_W-1:0] V_X    = PIX_W'(ROBOT_V);
  localparam logic [PIX_W-1:0] XMAX_X = PIX_W'(XMAX);
  localparam logic [PIX_W:0]   V11    = (PIX_W+1)'(ROBOT_V);
  localparam logic [PIX_W:0]   L11    = (PIX_W+1)'(L);
  localparam logic [PIX_W:0]   XMAX11 = (PIX_W+1)'(XMAX);

  robot_state_t     state, state_next;
  logic [PIX_W-1:0] x_next;
  logic [PIX_W:0]   x_up;

  // One extra bit so the bound comparison can never wrap.
  assign x_up = {1'b0, robot_x} + V11;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      robot_x <= L_X;
    end else begin
      state   <= state_next;
      robot_x <= x_next;
    end
  end

  always_comb begin
    state_next = state;
    x_next     = robot_x;
    if (frame_tick && run) begin
      case (state)
        IDLE: state_next = RIGHT;
        RIGHT: begin
          if (x_up > XMAX11) begin
            x_next     = XMAX_X;
            state_next = LEFT;
          end else begin
            x_next = x_up[PIX_W-1:0];
          end
        end
        LEFT: begin
          if ({1'b0, robot_x} < L11 + V11) begin
            x_next     = L_X;
            state_next = RIGHT;
          end else begin
            x_next = robot_x - V_X;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end
endmodule

// File: rtl/graphics_anim.sv
// graphics_anim: VGA pixel generator drawing N_WALLS wall columns over a
// yellow background plus a red robot sprite bouncing between the first and
// last wall.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   video_on           : high in the visible region
//   pix_x, pix_y       : current pixel from the sync generator
//   run                : enables robot motion
//   graph_rgb          : registered colour (1 clk latency)
//   frame_tick         : one-clk pulse at the start of line MAX_Y
import graphics_pkg::*;

module graphics_anim #(
  parameter int MAX_X      = 640,
  parameter int MAX_Y      = 480,
  parameter int N_WALLS    = 4,
  parameter int WALL_X0    = 30,
  parameter int WALL_W     = 10,
  parameter int WALL_PITCH = 160,
  parameter int ROBOT_SIZE = 16,
  parameter int ROBOT_Y    = 232,
  parameter int ROBOT_V    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             video_on,
  input  logic [PIX_W-1:0] pix_x,
  input  logic [PIX_W-1:0] pix_y,
  input  logic             run,
  output logic [2:0]       graph_rgb,
  output logic             frame_tick
);
  localparam int L    = WALL_X0 + WALL_W + 1;
  localparam int R    = WALL_X0 + (N_WALLS - 1) * WALL_PITCH - 1;
  localparam int XMAX = R - ROBOT_SIZE + 1;

  logic             cond, cond_d;
  logic [PIX_W-1:0] robot_x;
  logic             wall_hit, robot_hit;
  logic [2:0]       rgb_next;
  int               px, py, rx;

  // Edge-detect the frame condition so a slow pixel clock that holds
  // (0, MAX_Y) for several clk cycles still yields a single pulse.
  assign cond = (pix_y == PIX_W'(MAX_Y)) && (pix_x == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_d     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      cond_d     <= cond;
      frame_tick <= cond & ~cond_d;
    end
  end

  robot_mover #(
    .L       (L),
    .XMAX    (XMAX),
    .ROBOT_V (ROBOT_V)
  ) u_mover (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .run        (run),
    .robot_x    (robot_x)
  );

  always_comb begin
    px        = int'(pix_x);
    py        = int'(pix_y);
    rx        = int'(robot_x);
    wall_hit  = 1'b0;
    robot_hit = 1'b0;
    if (px < MAX_X && py < MAX_Y) begin
      for (int k = 0; k < N_WALLS; k++) begin
        if (px >= WALL_X0 + k * WALL_PITCH &&
            px <= WALL_X0 + k * WALL_PITCH + WALL_W)
          wall_hit = 1'b1;
      end
      robot_hit = (px >= rx) && (px <= rx + ROBOT_SIZE - 1) &&
                  (py >= ROBOT_Y) && (py <= ROBOT_Y + ROBOT_SIZE - 1);
    end
    if (!video_on)      rgb_next = COL_BLACK;
    else if (robot_hit) rgb_next = COL_ROBOT;
    else if (wall_hit)  rgb_next = COL_WALL;
    else                rgb_next = COL_BG;
  end

  // Output register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) graph_rgb <= COL_BLACK;
    else       graph_rgb <= rgb_next;
  end
endmodule

// File: tb/tb_graphics_anim.sv
// Self-checking bench for graphics_anim with default parameters.
import graphics_pkg::*;

module tb_graphics_anim;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       video_on = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic       run = 1'b0;
  logic [2:0] graph_rgb;
  logic       frame_tick;

  int checks = 0;
  int failures = 0;

  // Reference model: position and direction (0 idle, 1 right, 2 left)
  int mx = 41;
  int mdir = 0;

  graphics_anim dut (
    .clk        (clk),
    .reset      (reset),
    .video_on   (video_on),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .run        (run),
    .graph_rgb  (graph_rgb),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_col(input bit von, input int x, input int y, input int rx);
    if (!von) return 3'b000;
    if (x >= rx && x < rx + 16 && y >= 232 && y < 248) return 3'b100;
    for (int k = 0; k < 4; k++)
      if (x >= 30 + 160 * k && x <= 40 + 160 * k) return 3'b001;
    return 3'b110;
  endfunction

  function automatic int exp_state(input int d);
    if (d == 1) return int'(RIGHT);
    if (d == 2) return int'(LEFT);
    return int'(IDLE);
  endfunction

  task automatic model_step();
    if (!run) return;
    if (mdir == 0) mdir = 1;
    else if (mdir == 1) begin
      if (mx + 2 > 494) begin mx = 494; mdir = 2; end
      else mx = mx + 2;
    end else begin
      if (mx < 43) begin mx = 41; mdir = 1; end
      else mx = mx - 2;
    end
  endtask

  task automatic check_pix(input string tag, input bit von, input int x, input int y);
    @(negedge clk);
    video_on = von; pix_x = 10'(x); pix_y = 10'(y);
    @(negedge clk);
    check(tag, graph_rgb, exp_col(von, x, y, mx));
  endtask

  task automatic random_pixels(input int n);
    int x, y;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        x = mx - 3 + int'($urandom_range(0, 22));
        y = 228 + int'($urandom_range(0, 24));
      end else begin
        x = int'($urandom_range(0, 639));
        y = int'($urandom_range(0, 479));
      end
      check_pix("rand_pixel", 1'b1, x, y);
    end
  endtask

  task automatic do_tick();
    @(negedge clk);
    video_on = 1'b0; pix_x = 10'd0; pix_y = 10'd480;
    @(negedge clk);
    check("tick_pulse", frame_tick, 1);
    pix_x = 10'd1; pix_y = 10'd0;
    @(negedge clk);
    model_step();
  endtask

  task automatic check_pos(input string tag);
    check({tag, "_x"}, dut.u_mover.robot_x, mx);
    check({tag, "_state"}, int'(dut.u_mover.state), exp_state(mdir));
  endtask

  initial begin
    // Reset without any clock edge
    #2 reset = 1'b1;
    #1;
    check("reset_rgb", graph_rgb, 0);
    check("reset_tick", frame_tick, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_pos("reset");
    check_pix("robot_home", 1'b1, 41, 232);

    // Static colours
    check_pix("wall0", 1'b1, 35, 100);
    check_pix("wall1", 1'b1, 195, 10);
    check_pix("bg", 1'b1, 100, 10);
    check_pix("wall3", 1'b1, 515, 300);
    check_pix("wall0_edge_r", 1'b1, 40, 10);
    check_pix("wall0_past", 1'b1, 41, 10);
    check_pix("wall3_edge_l", 1'b1, 510, 10);
    for (int i = 0; i < 4; i++)
      check_pix("blank", 1'b0, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
    random_pixels(20);

    // Frame tick with a held frame condition
    @(negedge clk);
    video_on = 1'b0; pix_x = 10'd0; pix_y = 10'd480;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tick_hold", frame_tick, (i == 0) ? 1 : 0);
    end
    pix_y = 10'd481;
    @(negedge clk);
    check("tick_gap", frame_tick, 0);
    pix_y = 10'd480;
    @(negedge clk);
    check("tick_refire", frame_tick, 1);
    pix_x = 10'd1; pix_y = 10'd0;
    @(negedge clk);
    check("tick_end", frame_tick, 0);
    check_pos("run0_ticks");

    // Motion
    run = 1'b1;
    do_tick();
    check_pos("start");
    for (int i = 0; i < 10; i++) do_tick();
    check_pos("ten_ticks");
    check("ten_ticks_val", dut.u_mover.robot_x, 61);
    run = 1'b0;
    for (int i = 0; i < 5; i++) do_tick();
    check_pos("paused");
    random_pixels(10);

    // Bounce at the right end
    run = 1'b1;
    for (int i = 0; i < 216; i++) do_tick();
    check_pos("near_right");
    check("near_right_val", dut.u_mover.robot_x, 493);
    do_tick();
    check_pos("clamp_right");
    do_tick();
    check_pos("after_right");
    random_pixels(10);

    // Run down to the left bound
    for (int i = 0; i < 300 && !(mx == 41 && mdir == 1); i++) begin
      do_tick();
      check("down_x", dut.u_mover.robot_x, mx);
    end
    check_pos("clamp_left");
    check("clamp_left_val", dut.u_mover.robot_x, 41);
    do_tick();
    check_pos("after_left");
    random_pixels(10);

    // Travel until moving left through 300, then reset mid-motion
    for (int i = 0; i < 800 && !(mx == 300 && mdir == 2); i++) do_tick();
    check_pos("at_300");
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    mx = 41; mdir = 0;
    check_pos("mid_reset");
    check("mid_reset_rgb", graph_rgb, 0);
    @(negedge clk);
    reset = 1'b0;
    do_tick();
    check_pos("post_reset_tick");
    random_pixels(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
